polymult_tile: RTL and testbench

- Tiled schoolbook multiplier for two unsigned-coefficient polynomials A (POLY_A_WIDTH coefficients) and B (POLY_B_WIDTH coefficients).
- Consumes one A-tile/B-tile pair per accepted handshake and accumulates the partial products into a full-length product register.
- Streams the product C = A*B out in tiles of POLY_B_TILE_WIDTH coefficients, then signals done.
- Sits between the coefficient tile fetcher and the result writeback in the HE datapath.

---
 rtl/polymult_tile_if.sv | 27 ++
 rtl/polymult_tile.sv | 130 +++++++++++++
 tb/tb_polymult_tile.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/polymult_tile_if.sv
// Tile-pair input and product-beat output bundle for polymult_tile.
// master = tile producer/result consumer, slave = polymult_tile.
interface polymult_tile_if #(
  parameter int DATA_WIDTH        = 64,
  parameter int POLY_A_TILE_WIDTH = 8,
  parameter int POLY_B_TILE_WIDTH = 8
) ();
  logic inputs_ready_signal;
  logic [POLY_A_TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_a;
  logic [POLY_B_TILE_WIDTH-1:0][DATA_WIDTH-1:0] tile_b;
  logic ready_for_tile;
  logic [POLY_B_TILE_WIDTH-1:0][2*DATA_WIDTH-1:0] c_value_outputs;
  logic outputs_ready_signal;
  logic done;

  modport master (
    output inputs_ready_signal, tile_a, tile_b,
    input  ready_for_tile, c_value_outputs,
    input  outputs_ready_signal, done
  );

  modport slave (
    input  inputs_ready_signal, tile_a, tile_b,
    output ready_for_tile, c_value_outputs,
    output outputs_ready_signal, done
  );
endinterface

// File: rtl/polymult_tile.sv
// Tiled schoolbook polynomial multiplier: accumulates A-tile x B-tile
// partial products, then streams C = A*B in TB-lane beats and pulses done.
// Ports: clk, rst (async, active-high), bus (polymult_tile_if.slave).
module polymult_tile #(
  parameter int DATA_WIDTH        = 64,
  parameter int POLY_A_TILE_WIDTH = 8,
  parameter int POLY_B_TILE_WIDTH = 8,
  parameter int POLY_A_WIDTH      = 64,
  parameter int POLY_B_WIDTH      = 64
) (
  input  logic            clk,
  input  logic            rst,
  polymult_tile_if.slave  bus
);
  localparam int TA   = POLY_A_TILE_WIDTH;
  localparam int TB   = POLY_B_TILE_WIDTH;
  localparam int NA   = POLY_A_WIDTH / TA;
  localparam int NB   = POLY_B_WIDTH / TB;
  localparam int NC   = POLY_A_WIDTH + POLY_B_WIDTH - 1;
  localparam int NOUT = (NC + TB - 1) / TB;
  localparam int PW   = 2 * DATA_WIDTH;
  localparam int IW   = (NC > 1) ? $clog2(NC) : 1;
  localparam int AW   = (NA > 1) ? $clog2(NA) : 1;
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int KW   = (NOUT > 1) ? $clog2(NOUT) : 1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_ai;
  logic [BW-1:0]   r_bj;
  logic [KW-1:0]   r_beat;
  logic [PW-1:0]   r_acc [NC];
  logic [PW-1:0]   w_acc_next [NC];
  logic            w_accept;
  logic            w_last_pair;
  logic            w_last_beat;
  int              w_base;

  assign w_accept    = (r_state == S_LOAD) && bus.inputs_ready_signal;
  assign w_last_pair = (r_ai == AW'(NA - 1)) && (r_bj == BW'(NB - 1));
  assign w_last_beat = (r_beat == KW'(NOUT - 1));

  // Full-width products; every tile pair lands at offset TA*i+TB*j.
  always_comb begin
    w_acc_next = r_acc;
    w_base = TA * int'(r_ai) + TB * int'(r_bj);
    for (int p = 0; p < TA; p++) begin
      for (int q = 0; q < TB; q++) begin
        w_acc_next[IW'(w_base + p + q)] += PW'(bus.tile_a[p]) * PW'(bus.tile_b[q]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD:  if (w_accept && w_last_pair) w_next = S_DRAIN;
      S_DRAIN: if (w_last_beat) w_next = S_DONE;
      S_DONE:  w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ai   <= '0;
      r_bj   <= '0;
      r_beat <= '0;
      for (int n = 0; n < NC; n++) r_acc[n] <= '0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_acc <= w_acc_next;
            if (r_bj == BW'(NB - 1)) begin
              r_bj <= '0;
              r_ai <= w_last_pair ? '0 : r_ai + AW'(1);
            end else begin
              r_bj <= r_bj + BW'(1);
            end
          end
        end
        S_DRAIN: begin
          r_beat <= w_last_beat ? '0 : r_beat + KW'(1);
        end
        S_DONE: begin
          r_ai   <= '0;
          r_bj   <= '0;
          r_beat <= '0;
          for (int n = 0; n < NC; n++) r_acc[n] <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.ready_for_tile       = 1'b0;
    bus.outputs_ready_signal = 1'b0;
    bus.done                 = 1'b0;
    bus.c_value_outputs      = '0;
    unique case (r_state)
      S_LOAD:  bus.ready_for_tile = ~rst;
      S_DRAIN: begin
        bus.outputs_ready_signal = 1'b1;
        // Lanes past the last coefficient stay zero.
        for (int l = 0; l < TB; l++) begin
          if (TB * int'(r_beat) + l < NC)
            bus.c_value_outputs[l] = r_acc[IW'(TB * int'(r_beat) + l)];
        end
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_polymult_tile.sv
// Scoreboard bench for polymult_tile: a direct convolution model pushes
// expected beats; a negedge monitor pops and compares them.
module tb_polymult_tile;
  localparam int DW   = 64;
  localparam int TA   = 8;
  localparam int TB   = 8;
  localparam int PA   = 64;
  localparam int PB   = 64;
  localparam int NA   = PA / TA;
  localparam int NB   = PB / TB;
  localparam int NC   = PA + PB - 1;
  localparam int NOUT = (NC + TB - 1) / TB;

  typedef logic [2*DW-1:0] c_t;
  typedef logic [TB-1:0][2*DW-1:0] beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  polymult_tile_if #(
    .DATA_WIDTH(DW),
    .POLY_A_TILE_WIDTH(TA),
    .POLY_B_TILE_WIDTH(TB)
  ) bus ();

  polymult_tile #(
    .DATA_WIDTH(DW),
    .POLY_A_TILE_WIDTH(TA),
    .POLY_B_TILE_WIDTH(TB),
    .POLY_A_WIDTH(PA),
    .POLY_B_WIDTH(PB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  logic [DW-1:0] A [PA];
  logic [DW-1:0] B [PB];
  c_t C [NC];
  beat_t sb [$];
  beat_t exp_beat;

  task automatic chk(string tag, c_t got, c_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic clear_ab();
    for (int n = 0; n < PA; n++) A[n] = '0;
    for (int n = 0; n < PB; n++) B[n] = '0;
  endtask

  task automatic model_push();
    beat_t b;
    for (int n = 0; n < NC; n++) C[n] = '0;
    for (int a = 0; a < PA; a++)
      for (int k = 0; k < PB; k++)
        C[a+k] += c_t'(A[a]) * c_t'(B[k]);
    for (int k = 0; k < NOUT; k++) begin
      for (int l = 0; l < TB; l++)
        b[l] = (TB*k + l < NC) ? C[TB*k + l] : '0;
      sb.push_back(b);
    end
  endtask

  task automatic send(bit stall, int npairs);
    for (int n = 0; n < npairs; n++) begin
      int i = n / NB;
      int j = n % NB;
      while (stall && $urandom_range(0, 1) == 1) begin
        @(negedge clk);
        bus.inputs_ready_signal = 1'b0;
        for (int p = 0; p < TA; p++) bus.tile_a[p] = rnd64();
        for (int q = 0; q < TB; q++) bus.tile_b[q] = rnd64();
      end
      @(negedge clk);
      bus.inputs_ready_signal = 1'b1;
      for (int p = 0; p < TA; p++) bus.tile_a[p] = A[TA*i + p];
      for (int q = 0; q < TB; q++) bus.tile_b[q] = B[TB*j + q];
    end
    @(negedge clk);
    bus.inputs_ready_signal = 1'b0;
    for (int p = 0; p < TA; p++) bus.tile_a[p] = rnd64();
  endtask

  task automatic wait_done(string tag);
    int cyc = 0;
    bit seen = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.done) seen = 1;
    end
    chk({tag, "_done_seen"}, c_t'(seen), 1);
    chk({tag, "_done_lat"}, c_t'(cyc), NOUT);
    @(negedge clk);
    chk({tag, "_done_pulse"}, c_t'(bus.done), 0);
    chk({tag, "_ready_after"}, c_t'(bus.ready_for_tile), 1);
    chk({tag, "_sb_empty"}, c_t'(sb.size()), 0);
  endtask

  task automatic run(string tag, bit stall);
    model_push();
    send(stall, NA*NB);
    wait_done(tag);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) n_done++;
      if (bus.outputs_ready_signal) begin
        if (sb.size() == 0) begin
          chk("spurious_beat", 1, 0);
        end else begin
          exp_beat = sb.pop_front();
          for (int l = 0; l < TB; l++)
            chk($sformatf("beat_lane%0d", l), bus.c_value_outputs[l], exp_beat[l]);
        end
      end else begin
        chk("idle_zero", c_t'(|bus.c_value_outputs), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.inputs_ready_signal = 1'b0;
    bus.tile_a = '0;
    bus.tile_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", c_t'(bus.ready_for_tile), 0);
    chk("rst_ovalid", c_t'(bus.outputs_ready_signal), 0);
    chk("rst_done", c_t'(bus.done), 0);
    chk("rst_cout", c_t'(|bus.c_value_outputs), 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", c_t'(bus.ready_for_tile), 1);
    repeat (5) @(negedge clk);
    chk("no_done_idle", c_t'(n_done), 0);

    for (int n = 0; n < PA; n++) A[n] = 64'd1;
    for (int n = 0; n < PB; n++) B[n] = 64'd1;
    run("ones", 0);

    clear_ab();
    A[0] = 64'd3;
    B[5] = 64'd7;
    run("single", 0);

    clear_ab();
    A[0] = '1;
    B[0] = '1;
    run("max1", 0);

    clear_ab();
    A[0] = '1; A[1] = '1;
    B[0] = '1; B[1] = '1;
    run("max2", 0);

    for (int n = 0; n < PA; n++) A[n] = 64'd1;
    for (int n = 0; n < PB; n++) B[n] = 64'd1;
    run("ones_stall", 1);

    for (int n = 0; n < PA; n++) A[n] = rnd64();
    for (int n = 0; n < PB; n++) B[n] = rnd64();
    run("rand_stall", 1);

    for (int n = 0; n < PA; n++) A[n] = rnd64();
    for (int n = 0; n < PB; n++) B[n] = rnd64();
    send(0, 30);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", c_t'(bus.ready_for_tile), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int n = 0; n < PA; n++) A[n] = rnd64();
    for (int n = 0; n < PB; n++) B[n] = rnd64();
    run("fresh", 0);

    chk("done_count", c_t'(n_done), 7);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
